// File: rtl/lp_dma_if.sv
// lp_dma_if: print-buffer read bus and downstream byte stream of the LP20 DMA.
interface lp_dma_if;
  logic        devREQO;
  logic        devACKI;
  logic [17:0] devADDRO;
  logic [35:0] lpDATAI;
  logic [7:0]  lpBYTE;
  logic        lpBYTEV;
  logic        lpBYTEA;
  modport master (output devREQO, devADDRO, lpBYTE, lpBYTEV, input devACKI, lpDATAI, lpBYTEA);
  modport slave  (input devREQO, devADDRO, lpBYTE, lpBYTEV, output devACKI, lpDATAI, lpBYTEA);
endinterface

// File: rtl/lp_dma.sv
// lp_dma: LP20 byte-DMA sequencer, one byte per bus read, BAR/BCTR advance per byte.
module lp_dma #(
  parameter int TIMEOUT = 127
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         lpCMDGO,
  input  logic         lpABORT,
  input  logic         barLD,
  input  logic [17:0]  barIN,
  input  logic         bctrLD,
  input  logic [11:0]  bctrIN,
  lp_dma_if.master     bus,
  output logic [17:0]  regBAR,
  output logic [11:0]  regBCTR,
  output logic         lpBUSY,
  output logic         lpDONE,
  output logic         lpNXM
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FIN} state_t;
  state_t        state;
  logic [TW-1:0] tmo;
  logic [7:0]    lp_byte;
  logic [7:0]    lane;
  // Byte order within the 36-bit word follows the LP20 packing, not bit order.
  always_comb
    lane = regBAR[1] ? (regBAR[0] ? bus.lpDATAI[15:8]  : bus.lpDATAI[7:0])
                     : (regBAR[0] ? bus.lpDATAI[33:26] : bus.lpDATAI[25:18]);
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state   <= IDLE;
      regBAR  <= '0;
      regBCTR <= '0;
      lp_byte <= '0;
      tmo     <= '0;
      lpNXM   <= 1'b0;
    end else if (state != IDLE && lpABORT) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (barLD) regBAR <= barIN;
          if (bctrLD) regBCTR <= bctrIN;
          if (lpCMDGO) begin
            lpNXM <= 1'b0;
            tmo   <= '0;
            state <= regBCTR != '0 ? REQ : FIN;
          end
        end
        REQ:
          if (bus.devACKI) begin
            lp_byte <= lane;
            regBAR  <= regBAR + 18'd1;
            regBCTR <= regBCTR + 12'd1;
            state   <= HOLD;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            lpNXM <= 1'b1;
            state <= FIN;
          end else begin
            tmo <= tmo + 1'b1;
          end
        HOLD:
          if (bus.lpBYTEA) begin
            tmo   <= '0;
            state <= regBCTR == '0 ? FIN : REQ;
          end
        FIN: state <= IDLE;
      endcase
    end
  assign bus.devREQO  = state == REQ;
  assign bus.lpBYTEV  = state == HOLD;
  assign bus.lpBYTE   = lp_byte;
  assign bus.devADDRO = {regBAR[17:2], 2'b00};
  assign lpBUSY       = state != IDLE;
  assign lpDONE       = state == FIN;
endmodule

// File: tb/tb_lp_dma.sv
// tb_lp_dma: randomized transfers against a transaction-level byte-stream model.
module tb_lp_dma;
  logic        clk = 0, rstN = 0, lpCMDGO = 0, lpABORT = 0, barLD = 0, bctrLD = 0;
  logic [17:0] barIN = '0;
  logic [11:0] bctrIN = '0;
  logic [17:0] regBAR;
  logic [11:0] regBCTR;
  logic        lpBUSY, lpDONE, lpNXM;
  logic        fixed = 0;
  logic [35:0] seed;
  int          n_cmp = 0, n_bad = 0;

  lp_dma_if bus();

  lp_dma dut (
    .clk(clk), .rstN(rstN), .lpCMDGO(lpCMDGO), .lpABORT(lpABORT),
    .barLD(barLD), .barIN(barIN), .bctrLD(bctrLD), .bctrIN(bctrIN),
    .bus(bus), .regBAR(regBAR), .regBCTR(regBCTR),
    .lpBUSY(lpBUSY), .lpDONE(lpDONE), .lpNXM(lpNXM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: each word address maps to a seeded pattern.
  function automatic logic [35:0] mw(input logic [15:0] wa);
    return fixed ? 36'o123456654321 : ({wa, 4'h0, wa} ^ seed);
  endfunction

  function automatic logic [7:0] lane(input logic [35:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return w[25:18];
      2'd1:    return w[33:26];
      2'd2:    return w[7:0];
      default: return w[15:8];
    endcase
  endfunction

  task automatic load(input logic [17:0] b, input logic [11:0] c);
    @(negedge clk);
    barLD = 1; bctrLD = 1; barIN = b; bctrIN = c;
    @(negedge clk);
    barLD = 0; bctrLD = 0; barIN = 18'($urandom); bctrIN = 12'($urandom);
    chk("bar_load", 36'(regBAR), 36'(b));
    chk("bctr_load", 36'(regBCTR), 36'(c));
  endtask

  task automatic go();
    lpCMDGO = 1;
    @(negedge clk);
    lpCMDGO = 0;
  endtask

  task automatic xfer(input logic [17:0] b, input int n, input int ack_max,
                      input int acc_min, input int acc_max, input bit junk);
    int acks = 0, accs = 0, rc = 0, vc = 0, cyc = 0, aw, vw;
    bit done = 0;
    logic [17:0] a, eb;
    load(b, 12'(-n));
    aw = $urandom_range(0, ack_max);
    vw = $urandom_range(acc_min, acc_max);
    go();
    while (!done && cyc < 200 * n + 50) begin
      a = b + 18'(accs);
      if (lpDONE) done = 1;
      chk("req_vs_valid", 36'(bus.devREQO & bus.lpBYTEV), 36'(0));
      if (bus.devREQO) begin
        chk("addr", 36'(bus.devADDRO), 36'({a[17:2], 2'b00}));
        bus.devACKI = rc >= aw;
        bus.lpDATAI = mw(a[17:2]);
        if (bus.devACKI) begin acks++; rc = 0; aw = $urandom_range(0, ack_max); end
        else rc++;
      end else begin
        bus.devACKI = 0;
        bus.lpDATAI = 36'($urandom);
      end
      if (bus.lpBYTEV) begin
        chk("byte", 36'(bus.lpBYTE), 36'(lane(mw(a[17:2]), a[1:0])));
        bus.lpBYTEA = vc >= vw;
        if (bus.lpBYTEA) begin accs++; vc = 0; vw = $urandom_range(acc_min, acc_max); end
        else vc++;
      end else bus.lpBYTEA = 1'($urandom_range(0, 1));
      lpCMDGO = junk && !done && $urandom_range(0, 3) == 0;
      barLD   = junk && !done && $urandom_range(0, 3) == 0;
      bctrLD  = junk && !done && $urandom_range(0, 3) == 0;
      barIN   = 18'($urandom);
      bctrIN  = 12'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.devACKI = 0; bus.lpBYTEA = 0;
    eb = b + 18'(n);
    chk("done_seen", 36'(done), 36'(1));
    chk("done_pulse", 36'(lpDONE), 36'(0));
    chk("idle_after", 36'(lpBUSY), 36'(0));
    chk("bar_end", 36'(regBAR), 36'(eb));
    chk("bctr_end", 36'(regBCTR), 36'(0));
    chk("acks", 36'(acks), 36'(n));
    chk("accepts", 36'(accs), 36'(n));
    chk("nxm_clear", 36'(lpNXM), 36'(0));
  endtask

  initial begin
    logic [17:0] b;
    int hi, cyc;
    seed = {4'($urandom), 32'($urandom)};
    bus.devACKI = 0; bus.lpDATAI = '0; bus.lpBYTEA = 0;
    repeat (2) @(negedge clk);
    chk("rst_bar", 36'(regBAR), 36'(0));
    chk("rst_bctr", 36'(regBCTR), 36'(0));
    chk("rst_outs", 36'({bus.devREQO, bus.lpBYTEV, lpBUSY, lpDONE, lpNXM, bus.lpBYTE}), 36'(0));
    rstN = 1;

    // Fixed word through all four lanes, accept tied high.
    fixed = 1;
    xfer(18'o1000, 4, 3, 0, 0, 0);
    fixed = 0;

    // Zero count: straight to completion, no bus request.
    load(18'($urandom), 12'd0);
    go();
    chk("zero_done", 36'(lpDONE), 36'(1));
    chk("zero_noreq", 36'(bus.devREQO), 36'(0));
    @(negedge clk);
    chk("zero_done_end", 36'(lpDONE), 36'(0));
    chk("zero_idle", 36'(lpBUSY), 36'(0));
    chk("zero_noreq2", 36'(bus.devREQO), 36'(0));

    // Backpressure: accept held off ten cycles per byte.
    xfer(18'($urandom), 2, 2, 10, 10, 0);

    // Random transfers, some crossing the address wrap, junk on ignored inputs.
    for (int i = 0; i < 8; i++) begin
      b = (i % 3 == 0) ? 18'h3fffc + 18'($urandom_range(0, 3)) : 18'($urandom);
      xfer(b, $urandom_range(1, 6), 4, 0, 3, i[0]);
    end

    // Timeout: never acknowledge.
    b = 18'($urandom);
    load(b, 12'hffd);
    go();
    hi = 0; cyc = 0;
    while (!lpDONE && cyc < 400) begin
      if (bus.devREQO) hi++;
      @(negedge clk);
      cyc++;
    end
    chk("tmo_req_cycles", 36'(hi), 36'(127));
    chk("tmo_done", 36'(lpDONE), 36'(1));
    chk("tmo_nxm", 36'(lpNXM), 36'(1));
    chk("tmo_bar", 36'(regBAR), 36'(b));
    chk("tmo_bctr", 36'(regBCTR), 36'(12'hffd));
    @(negedge clk);
    chk("tmo_nxm_sticky", 36'(lpNXM), 36'(1));
    chk("tmo_idle", 36'(lpBUSY), 36'(0));
    go();
    chk("go_clears_nxm", 36'(lpNXM), 36'(0));
    chk("go_req", 36'(bus.devREQO), 36'(1));
    lpABORT = 1;
    @(negedge clk);
    lpABORT = 0;
    chk("abort_req_idle", 36'(lpBUSY), 36'(0));

    // Abort colliding with acknowledge.
    b = 18'($urandom);
    load(b, 12'hffd);
    go();
    chk("col_req", 36'(bus.devREQO), 36'(1));
    bus.devACKI = 1; bus.lpDATAI = mw(b[17:2]); lpABORT = 1;
    @(negedge clk);
    bus.devACKI = 0; lpABORT = 0;
    chk("col_idle", 36'(lpBUSY), 36'(0));
    chk("col_noreq", 36'(bus.devREQO), 36'(0));
    chk("col_bar", 36'(regBAR), 36'(b));
    chk("col_bctr", 36'(regBCTR), 36'(12'hffd));
    for (int i = 0; i < 3; i++) begin
      chk("col_nodone", 36'(lpDONE), 36'(0));
      chk("col_novalid", 36'(bus.lpBYTEV), 36'(0));
      @(negedge clk);
    end

    // Address wrap, then asynchronous reset while holding the byte.
    load(18'o777777, 12'hfff);
    go();
    chk("wrap_req", 36'(bus.devREQO), 36'(1));
    bus.devACKI = 1; bus.lpDATAI = mw(16'hffff);
    @(negedge clk);
    bus.devACKI = 0;
    chk("wrap_valid", 36'(bus.lpBYTEV), 36'(1));
    chk("wrap_bar", 36'(regBAR), 36'(0));
    chk("wrap_bctr", 36'(regBCTR), 36'(0));
    chk("wrap_byte", 36'(bus.lpBYTE), 36'(lane(mw(16'hffff), 2'd3)));
    #1 rstN = 0;
    #1;
    chk("arst_bar", 36'(regBAR), 36'(0));
    chk("arst_bctr", 36'(regBCTR), 36'(0));
    chk("arst_outs", 36'({bus.devREQO, bus.lpBYTEV, lpBUSY, lpDONE, lpNXM, bus.lpBYTE}), 36'(0));
    @(negedge clk);
    rstN = 1;
    @(negedge clk);
    chk("post_rst_nodone", 36'(lpDONE), 36'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
